system_workers_cpu_debug_scan_master: RTL and testbench

- Clocked driver for the CPU debug slave's virtual-JTAG port; the initiator end of the debug slave's scan interface.
- Takes (IR, DR) scan commands on a valid/ready interface and produces a divided tck, tdi, ir_in and the virtual-state strobes (uir/cdr/sdr/udr/rti) in the order the debug slave expects.
- Collects tdo into a response word and returns the captured ir_out.
- Used for on-chip debug bring-up and as the stimulus engine in debug-slave simulation benches.

---
 rtl/system_workers_cpu_debug_scan_master.sv | 182 ++++++++++++++++++
 tb/tb_system_workers_cpu_debug_scan_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/system_workers_cpu_debug_scan_master.sv
// Initiator for the CPU debug slave's virtual-JTAG port. Accepts (IR, DR)
// scan commands, walks the UIR -> CDR -> SHIFT -> UDR -> RTI virtual states
// with a divided tck, shifts the DR word out LSB first while capturing tdo,
// and returns the captured word plus the slave's ir_out as a response.
module system_workers_cpu_debug_scan_master #(
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    input  logic                cmd_ir_only,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int PW   = $clog2(2 * TCK_DIV);
    localparam int CMAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int BW   = $clog2(CMAX + 1);

    // Period counter landmarks: last low-half cycle, first high-half cycle, wrap.
    localparam logic [PW-1:0] P_SAMPLE = PW'(TCK_DIV - 1);
    localparam logic [PW-1:0] P_HIGH   = PW'(TCK_DIV);
    localparam logic [PW-1:0] P_LAST   = PW'(2 * TCK_DIV - 1);
    localparam logic [PW-1:0] P_ONE    = PW'(1);
    localparam logic [BW-1:0] DR_LAST  = BW'(DR_WIDTH - 1);
    localparam logic [BW-1:0] RTI_LAST = BW'(RTI_CYCLES - 1);
    localparam logic [BW-1:0] B_ONE    = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UIR   = 3'd1,
        S_CDR   = 3'd2,
        S_SHIFT = 3'd3,
        S_UDR   = 3'd4,
        S_RTI   = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_cnt;
    logic [BW-1:0]         r_bit;
    logic [DR_WIDTH-1:0]   r_sr;
    logic                  r_ir_only;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DR_WIDTH-1:0]   r_rsp_dr;
    logic [IR_WIDTH-1:0]   r_rsp_ir_out;
    logic                  r_tck;
    logic                  r_tdi;
    logic [IR_WIDTH-1:0]   r_ir_in;
    logic                  r_uir;
    logic                  r_cdr;
    logic                  r_sdr;
    logic                  r_udr;
    logic                  r_rti;

    state_t                w_state_nxt;
    logic                  w_active;
    logic                  w_nxt_active;
    logic                  w_period_end;
    logic                  w_accept;
    logic [PW-1:0]         w_cnt_nxt;
    logic [DR_WIDTH-1:0]   w_sr_shifted;

    // Next-state decode: every scan state advances only at a tck period boundary.
    always_comb begin
        w_active     = (r_state != S_IDLE) && (r_state != S_RESP);
        w_period_end = w_active && (r_cnt == P_LAST);
        w_accept     = cmd_valid && r_cmd_ready;
        w_sr_shifted = r_sr >> 1'b1;
        w_sr_shifted[DR_WIDTH-1] = vji_tdo;
        w_state_nxt  = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_accept ? S_UIR : S_IDLE;
            S_UIR:   w_state_nxt = w_period_end ? (r_ir_only ? S_RTI : S_CDR) : S_UIR;
            S_CDR:   w_state_nxt = w_period_end ? S_SHIFT : S_CDR;
            S_SHIFT: w_state_nxt = (w_period_end && (r_bit == DR_LAST)) ? S_UDR : S_SHIFT;
            S_UDR:   w_state_nxt = w_period_end ? S_RTI : S_UDR;
            S_RTI:   w_state_nxt = (w_period_end && (r_bit == RTI_LAST)) ? S_RESP : S_RTI;
            S_RESP:  w_state_nxt = rsp_ready ? S_IDLE : S_RESP;
            default: w_state_nxt = S_IDLE;
        endcase
        w_nxt_active = (w_state_nxt != S_IDLE) && (w_state_nxt != S_RESP);
        w_cnt_nxt    = (w_active && w_nxt_active && !w_period_end) ? (r_cnt + P_ONE) : '0;
    end

    // Scan sequencer: state, tck divider, shift register and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_sr         <= '0;
            r_ir_only    <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_dr     <= '0;
            r_rsp_ir_out <= '0;
            r_tck        <= 1'b0;
            r_tdi        <= 1'b0;
            r_ir_in      <= '0;
            r_uir        <= 1'b0;
            r_cdr        <= 1'b0;
            r_sdr        <= 1'b0;
            r_udr        <= 1'b0;
            r_rti        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            // tck is low for the first TCK_DIV cycles of a period, high after.
            r_tck       <= w_nxt_active && (w_cnt_nxt >= P_HIGH);
            r_uir       <= (w_state_nxt == S_UIR);
            r_cdr       <= (w_state_nxt == S_CDR);
            r_sdr       <= (w_state_nxt == S_SHIFT);
            r_udr       <= (w_state_nxt == S_UDR);
            r_rti       <= (w_state_nxt == S_RTI);
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);

            if (w_accept) begin
                r_ir_in   <= cmd_ir;
                r_sr      <= cmd_dr;
                r_ir_only <= cmd_ir_only;
            end else if ((r_state == S_SHIFT) && (r_cnt == P_SAMPLE)) begin
                // Sample tdo on the last low cycle; the shift lands on the tck rising edge.
                r_sr <= w_sr_shifted;
            end

            // Bit/RTI counter restarts on each state change, steps per period otherwise.
            if (w_accept) begin
                r_bit <= '0;
            end else if (w_period_end) begin
                r_bit <= (w_state_nxt != r_state) ? '0 : (r_bit + B_ONE);
            end

            // tdi changes only at period start (tck falling) and idles low outside SHIFT.
            if (w_period_end) begin
                r_tdi <= (w_state_nxt == S_SHIFT) ? r_sr[0] : 1'b0;
            end

            if ((r_state == S_UIR) && w_period_end) begin
                r_rsp_ir_out <= vji_ir_out;
            end

            if ((r_state == S_RTI) && (w_state_nxt == S_RESP)) begin
                r_rsp_dr <= r_ir_only ? '0 : r_sr;
            end
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dr     = r_rsp_dr;
    assign rsp_ir_out = r_rsp_ir_out;
    assign vji_tck    = r_tck;
    assign vji_tdi    = r_tdi;
    assign vji_ir_in  = r_ir_in;
    assign vji_uir    = r_uir;
    assign vji_cdr    = r_cdr;
    assign vji_sdr    = r_sdr;
    assign vji_udr    = r_udr;
    assign vji_rti    = r_rti;

endmodule

// File: tb/tb_system_workers_cpu_debug_scan_master.sv
// Directed bench for the debug scan master with a behavioural virtual-JTAG
// slave: 38-bit DR captured at CDR, shifted on tck rising while sdr is high.
module tb_system_workers_cpu_debug_scan_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ir = 2'b00;
    logic [37:0] cmd_dr = 38'h0;
    logic        cmd_ir_only = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [37:0] rsp_dr;
    logic [1:0]  rsp_ir_out;
    logic        vji_tck, vji_tdi, vji_tdo;
    logic [1:0]  vji_ir_in, vji_ir_out;
    logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic [37:0] slave_sr;
    logic [37:0] slave_init = 38'h0;
    logic [37:0] slave_at_udr = 38'h0;
    logic [1:0]  slave_ir_out = 2'b00;

    int n_cmp = 0;
    int n_bad = 0;
    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0, n_ovl = 0, n_rise = 0;
    int s_uir, s_cdr, s_sdr, s_udr, s_rti, s_ovl, s_rise;
    int d_uir, d_cdr, d_sdr, d_udr, d_rti, d_ovl, d_rise;
    logic [29:0] order_log = 30'h0;
    logic [2:0]  prev_code = 3'd0;

    system_workers_cpu_debug_scan_master #(
        .DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(1), .RTI_CYCLES(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .cmd_ir_only(cmd_ir_only),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    always #5 clk = ~clk;

    assign vji_tdo    = slave_sr[0];
    assign vji_ir_out = slave_ir_out;

    // Slave DR: capture on CDR, shift tdi in at the top on each SHIFT tck rise.
    always @(posedge vji_tck) begin
        if (vji_cdr) slave_sr <= slave_init;
        else if (vji_sdr) slave_sr <= {vji_tdi, slave_sr[37:1]};
    end

    always @(posedge vji_tck) if (vji_sdr) n_rise++;

    always @(posedge vji_udr) slave_at_udr = slave_sr;

    // Strobe monitor: per-strobe cycle counts, overlap count, order of entry.
    always @(negedge clk) begin
        logic [2:0] code;
        n_uir += int'(vji_uir);
        n_cdr += int'(vji_cdr);
        n_sdr += int'(vji_sdr);
        n_udr += int'(vji_udr);
        n_rti += int'(vji_rti);
        if ((int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) + int'(vji_rti)) > 1) n_ovl++;
        code = vji_uir ? 3'd1 : vji_cdr ? 3'd2 : vji_sdr ? 3'd3 : vji_udr ? 3'd4 : vji_rti ? 3'd5 : 3'd0;
        if (code != 3'd0 && code != prev_code) order_log = {order_log[26:0], code};
        prev_code = code;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Drives one command through to its response; lat = negedges from acceptance to rsp_valid.
    task automatic run_scan(input logic [1:0] ir, input logic [37:0] dr, input logic ir_only,
                            output int lat, output logic [37:0] dr_out, output logic [1:0] irout);
        int w;
        cmd_ir = ir; cmd_dr = dr; cmd_ir_only = ir_only; cmd_valid = 1'b1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        s_uir = n_uir; s_cdr = n_cdr; s_sdr = n_sdr; s_udr = n_udr; s_rti = n_rti;
        s_ovl = n_ovl; s_rise = n_rise;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
        dr_out = rsp_dr; irout = rsp_ir_out;
        d_uir = n_uir - s_uir; d_cdr = n_cdr - s_cdr; d_sdr = n_sdr - s_sdr;
        d_udr = n_udr - s_udr; d_rti = n_rti - s_rti; d_ovl = n_ovl - s_ovl; d_rise = n_rise - s_rise;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] got;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = {cmd_ready, vji_tck, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, rsp_valid};
            n_cmp++;
            if (got !== 8'b1000_0000) begin
                n_bad++; $display("FAIL reset_idle cyc%0d: got %b expected 10000000", i, got);
            end
        end
        n_cmp++;
        if ({rsp_dr, vji_ir_in, vji_tdi} !== 41'h0) begin
            n_bad++; $display("FAIL reset_data: got dr=%h ir_in=%b tdi=%b expected 0", rsp_dr, vji_ir_in, vji_tdi);
        end
    endtask

    task automatic test_full_scan;
        int lat; logic [37:0] d; logic [1:0] iro;
        slave_init = 38'h2A_5555_5555; slave_ir_out = 2'b10;
        run_scan(2'b01, 38'h00_0000_00AB, 1'b0, lat, d, iro);
        n_cmp++; if (lat !== 85) begin n_bad++; $display("FAIL full_latency: got %0d expected 85", lat); end
        n_cmp++; if (d !== 38'h2A_5555_5555) begin n_bad++; $display("FAIL full_rsp_dr: got %h expected 2a55555555", d); end
        n_cmp++; if (slave_at_udr !== 38'h00_0000_00AB) begin n_bad++; $display("FAIL full_slave_dr: got %h expected ab", slave_at_udr); end
        n_cmp++; if (vji_ir_in !== 2'b01) begin n_bad++; $display("FAIL full_ir_in: got %b expected 01", vji_ir_in); end
        n_cmp++; if (iro !== 2'b10) begin n_bad++; $display("FAIL full_ir_out: got %b expected 10", iro); end
    endtask

    task automatic test_strobe_order;
        logic [14:0] exp_order;
        exp_order = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        n_cmp++;
        if ({d_uir, d_cdr, d_sdr, d_udr, d_rti} !== {32'd2, 32'd2, 32'd76, 32'd2, 32'd2}) begin
            n_bad++; $display("FAIL strobe_lengths: got uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d expected 2 2 76 2 2",
                              d_uir, d_cdr, d_sdr, d_udr, d_rti);
        end
        n_cmp++; if (d_ovl !== 0) begin n_bad++; $display("FAIL strobe_overlap: got %0d expected 0", d_ovl); end
        n_cmp++; if (d_rise !== 38) begin n_bad++; $display("FAIL sdr_tck_rises: got %0d expected 38", d_rise); end
        n_cmp++; if (order_log[14:0] !== exp_order) begin n_bad++; $display("FAIL strobe_order: got %h expected %h", order_log[14:0], exp_order); end
    endtask

    task automatic test_ir_only;
        int lat; logic [37:0] d; logic [1:0] iro; logic [5:0] exp_order;
        exp_order = {3'd1, 3'd5};
        slave_ir_out = 2'b11;
        run_scan(2'b10, 38'h3F_FFFF_FFFF, 1'b1, lat, d, iro);
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL ironly_latency: got %0d expected 5", lat); end
        n_cmp++; if (iro !== 2'b11) begin n_bad++; $display("FAIL ironly_ir_out: got %b expected 11", iro); end
        n_cmp++; if (d !== 38'h0) begin n_bad++; $display("FAIL ironly_rsp_dr: got %h expected 0", d); end
        n_cmp++;
        if ({d_uir, d_cdr, d_sdr, d_udr, d_rti} !== {32'd2, 32'd0, 32'd0, 32'd0, 32'd2}) begin
            n_bad++; $display("FAIL ironly_strobes: got uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d expected 2 0 0 0 2",
                              d_uir, d_cdr, d_sdr, d_udr, d_rti);
        end
        n_cmp++; if (order_log[5:0] !== exp_order) begin n_bad++; $display("FAIL ironly_order: got %h expected %h", order_log[5:0], exp_order); end
        n_cmp++; if (vji_ir_in !== 2'b10) begin n_bad++; $display("FAIL ironly_ir_in: got %b expected 10", vji_ir_in); end
    endtask

    task automatic test_back_to_back;
        int w; int bad; int lat;
        slave_init = 38'h12_3456_789A; slave_ir_out = 2'b01;
        cmd_ir = 2'b11; cmd_dr = 38'h00_0000_003C; cmd_ir_only = 1'b0; cmd_valid = 1'b1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        @(negedge clk);
        cmd_ir = 2'b01; cmd_dr = 38'h3F_0000_0001;
        w = 0;
        while (rsp_valid !== 1'b1 && w < 400) begin @(negedge clk); w++; end
        n_cmp++; if (rsp_dr !== 38'h12_3456_789A) begin n_bad++; $display("FAIL b2b_first_dr: got %h expected 123456789a", rsp_dr); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || vji_ir_in !== 2'b11) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL b2b_hold: got %0d bad cycles expected 0", bad); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_release: got ready=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
        end
        slave_init = 38'h0A_BCDE_F012;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if ({cmd_ready, vji_uir, vji_ir_in} !== 4'b0101) begin
            n_bad++; $display("FAIL b2b_second_accept: got ready=%b uir=%b ir_in=%b expected 0 1 01", cmd_ready, vji_uir, vji_ir_in);
        end
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
        n_cmp++; if (lat !== 85) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected 85", lat); end
        n_cmp++; if (rsp_dr !== 38'h0A_BCDE_F012) begin n_bad++; $display("FAIL b2b_second_dr: got %h expected abcdef012", rsp_dr); end
        n_cmp++; if (slave_at_udr !== 38'h3F_0000_0001) begin n_bad++; $display("FAIL b2b_second_slave: got %h expected 3f00000001", slave_at_udr); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_scan;
        int w; int r0; int bad; int lat; logic [37:0] d; logic [1:0] iro; logic [8:0] got;
        slave_init = 38'h2A_AAAA_0000; slave_ir_out = 2'b01;
        cmd_ir = 2'b11; cmd_dr = 38'h3F_FFFF_FFFF; cmd_ir_only = 1'b0; cmd_valid = 1'b1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        r0 = n_rise;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while ((n_rise - r0) < 10 && w < 300) begin @(negedge clk); w++; end
        n_cmp++; if (w >= 300) begin n_bad++; $display("FAIL midreset_reach_shift: got timeout expected 10 shift periods"); end
        #2 reset_n = 1'b0;
        #1;
        got = {cmd_ready, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, rsp_valid};
        n_cmp++; if (got !== 9'b1_0000_0000) begin n_bad++; $display("FAIL midreset_ctrl: got %b expected 100000000", got); end
        n_cmp++;
        if ({rsp_dr, vji_ir_in, rsp_ir_out} !== 42'h0) begin
            n_bad++; $display("FAIL midreset_data: got dr=%h ir_in=%b ir_out=%b expected 0", rsp_dr, vji_ir_in, rsp_ir_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL midreset_after: got %0d bad cycles expected 0", bad); end
        slave_ir_out = 2'b10;
        run_scan(2'b10, 38'h15_5555_AAAA, 1'b0, lat, d, iro);
        n_cmp++; if (lat !== 85) begin n_bad++; $display("FAIL midreset_fresh_latency: got %0d expected 85", lat); end
        n_cmp++; if (d !== 38'h2A_AAAA_0000) begin n_bad++; $display("FAIL midreset_fresh_dr: got %h expected 2aaaaa0000", d); end
        n_cmp++; if (slave_at_udr !== 38'h15_5555_AAAA) begin n_bad++; $display("FAIL midreset_fresh_slave: got %h expected 155555aaaa", slave_at_udr); end
        n_cmp++; if (iro !== 2'b10) begin n_bad++; $display("FAIL midreset_fresh_ir_out: got %b expected 10", iro); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_strobe_order();
        test_ir_only();
        test_back_to_back();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
